carry_skip_adder: RTL and testbench
===================================

# carry_skip_adder

Parameterised carry-skip adder with a registered result. The operand width is split into fixed-size groups. Each group computes its internal carries with a prefix network of configurable valency. A group-propagate signal lets the incoming carry bypass any group whose bits all propagate. The sum and carry-out are captured in an output register, so the block drops into a clocked datapath as a one-cycle arithmetic stage.

## Interface
Clock/reset: one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst_n`.

Parameters:
- `WIDTH`, default 16: operand and sum width in bits. Must be a positive multiple of `GROUP`.
- `VALENCY`, default 2: radix of the in-group prefix tree. Must be 2 or greater.
- `GROUP`, default 4: bits per skip group. Must be 1 or greater.

Ports, in this instantiation order:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `A`, input, [WIDTH:1]: operand A. Bit 1 is the LSB.
- `B`, input, [WIDTH:1]: operand B. Bit 1 is the LSB.
- `Cin`, input, 1: carry-in.
- `S`, output, [WIDTH:1]: registered sum, A+B+Cin mod 2^WIDTH.
- `Cout`, output, 1: registered carry-out, bit WIDTH+1 of A+B+Cin.

## Operation
- Per-bit signals: g_i = A_i & B_i; p_i = A_i ^ B_i.
- Groups k = 0 .. WIDTH/GROUP-1 cover bits k*GROUP+1 .. (k+1)*GROUP.
- Within each group, compute prefix (G,P) with a tree of VALENCY-input combine cells.
  - Depth is ceil(log_VALENCY(GROUP)) levels.
  - Each cell is the associative operator (G,P) = (G_hi | P_hi&G_lo, P_hi&P_lo), generalised to VALENCY inputs.
- Group carry-in: c_0 = Cin.
- Group carry-out: c_{k+1} = P_grp_k ? c_k : (G_grp_k | P_grp_k&c_k).
  - The skip mux selects c_k when every bit of the group propagates.
- Internal bit carry: carry into bit j = G[j-1:grp_lsb] | P[j-1:grp_lsb]&c_k.
- Sum bit: S_j = p_j ^ carry into bit j.
- Cout = c_{WIDTH/GROUP}.
- The functional result must equal A+B+Cin exactly for every legal parameter set. VALENCY and GROUP change only structure, never values.
- All arithmetic is unsigned. Overflow is reported only through Cout; there is no saturation.

## Timing
- The adder core is purely combinational from A/B/Cin to next_S/next_Cout.
- S and Cout are registered on the rising edge of `clk`.
- Latency is 1 cycle: inputs stable before edge N appear on S/Cout after edge N.
- Throughput is one add per cycle. There is no handshake or valid signal.
- Reset:
  - `rst_n` low forces S=0 and Cout=0 immediately, independent of `clk`.
  - While low, the outputs hold 0 regardless of the inputs.
  - After `rst_n` deasserts, the first rising edge captures the current sum.
  - Asserting reset mid-stream discards the pending result. No partial state survives.
- Inputs that change between edges have no effect until the next edge.
- The combinational critical path is the in-group prefix tree plus WIDTH/GROUP skip muxes. No multicycle paths.

## Test plan
- Defaults (16/2/4). A=16'hFFFF, B=0, Cin=1, one edge → S=16'h0000, Cout=1. This is full carry ripple through every skip group.
- A=55000 (16'hD6D8), B=7000 (16'h1B58), Cin=1 → S=62001 (16'hF231), Cout=0.
- A=999, B=0, Cin=1 → S=1000 (16'h03E8), Cout=0. Then A=16'h8000, B=16'h8000, Cin=0 → S=0, Cout=1.
- Reset: load A=16'h1234, B=16'h1111, Cin=0, clock once, so S=16'h2345. Assert `rst_n` low between edges → S=0 and Cout=0 immediately. Hold for 2 edges → outputs stay 0. Release, then one edge → S=16'h2345.
- Back-to-back: apply three different vectors on consecutive edges. Each result must appear exactly one edge after its inputs, with no bubbles.
- Random sweep: run 10k random A, B, Cin against the A+B+Cin golden model. Repeat for parameter sets (16,2,4), (16,4,4), (32,2,8), (8,3,4), (12,2,3). All must match bit-exactly.

Source files
------------

// File: rtl/carry_skip_adder.sv
// Carry-skip adder: per-group prefix tree of VALENCY-input cells plus group skip muxes, result registered.
// Latency one cycle, one add per cycle, no handshake; rst_n clears S/Cout asynchronously.
module carry_skip_adder #(
   parameter int WIDTH   = 16,
   parameter int VALENCY = 2,
   parameter int GROUP   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH:1]   A,
   input  logic [WIDTH:1]   B,
   input  logic             Cin,
   output logic [WIDTH:1]   S,
   output logic             Cout
);

   function automatic int clog_v(input int n, input int v);
      int l = 0;
      int s = 1;
      while (s < n) begin
         s = s * v;
         l++;
      end
      return l;
   endfunction

   localparam int NGRP   = WIDTH / GROUP;
   localparam int LEVELS = clog_v(GROUP, VALENCY);

   // Level l of the tree combines each node with up to VALENCY-1 lower nodes spaced VALENCY**l apart,
   // so after LEVELS levels every position holds the prefix (G,P) from its group LSB.
   function automatic logic [WIDTH:0] csa_add(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             cin
   );
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] s;
      logic [GROUP-1:0] gg [0:LEVELS];
      logic [GROUP-1:0] pp [0:LEVELS];
      logic [NGRP:0]    c;
      logic             gacc;
      logic             pacc;
      logic             cbit;
      int               span;
      g    = a & b;
      p    = a ^ b;
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int k = 0; k < NGRP; k++) begin
         for (int i = 0; i < GROUP; i++) begin
            gg[0][i] = g[k*GROUP + i];
            pp[0][i] = p[k*GROUP + i];
         end
         span = 1;
         for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < GROUP; i++) begin
               gacc = gg[l][i];
               pacc = pp[l][i];
               for (int t = 1; t < VALENCY; t++) begin
                  if (i >= t*span) begin
                     gacc = gacc | (pacc & gg[l][i - t*span]);
                     pacc = pacc & pp[l][i - t*span];
                  end
               end
               gg[l+1][i] = gacc;
               pp[l+1][i] = pacc;
            end
            span = span * VALENCY;
         end
         for (int i = 0; i < GROUP; i++) begin
            if (i == 0)
               cbit = c[k];
            else
               cbit = gg[LEVELS][i-1] | (pp[LEVELS][i-1] & c[k]);
            s[k*GROUP + i] = p[k*GROUP + i] ^ cbit;
         end
         // Skip mux: a fully propagating group passes its carry-in straight through.
         c[k+1] = pp[LEVELS][GROUP-1] ? c[k] : gg[LEVELS][GROUP-1];
      end
      return {c[NGRP], s};
   endfunction

   logic [WIDTH:0] nxt_sum;

   always_comb begin
      nxt_sum = csa_add(A, B, Cin);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S    <= '0;
         Cout <= 1'b0;
      end else begin
         S    <= nxt_sum[WIDTH-1:0];
         Cout <= nxt_sum[WIDTH];
      end
   end

endmodule

// File: tb/tb_carry_skip_adder.sv
// Bench for carry_skip_adder: directed cases on the default build, random sweep over five parameter sets.
module tb_carry_skip_adder;

   logic clk;
   logic rst_n;

   logic [15:0] a0, b0, s0;  logic c0, co0;
   logic [15:0] a1, b1, s1;  logic c1, co1;
   logic [31:0] a2, b2, s2;  logic c2, co2;
   logic [7:0]  a3, b3, s3;  logic c3, co3;
   logic [11:0] a4, b4, s4;  logic c4, co4;

   int compared   = 0;
   int mismatched = 0;

   carry_skip_adder #(.WIDTH(16), .VALENCY(2), .GROUP(4)) u0 (
      .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .Cin(c0), .S(s0), .Cout(co0));
   carry_skip_adder #(.WIDTH(16), .VALENCY(4), .GROUP(4)) u1 (
      .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1));
   carry_skip_adder #(.WIDTH(32), .VALENCY(2), .GROUP(8)) u2 (
      .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .Cin(c2), .S(s2), .Cout(co2));
   carry_skip_adder #(.WIDTH(8), .VALENCY(3), .GROUP(4)) u3 (
      .clk(clk), .rst_n(rst_n), .A(a3), .B(b3), .Cin(c3), .S(s3), .Cout(co3));
   carry_skip_adder #(.WIDTH(12), .VALENCY(2), .GROUP(3)) u4 (
      .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(c4), .S(s4), .Cout(co4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [15:0] a, input logic [15:0] b, input logic c);
      a0 = a;
      b0 = b;
      c0 = c;
   endtask

   logic [32:0] e0, e1, e2, e3, e4;

   initial begin
      rst_n = 1'b0;
      drive0(16'h0, 16'h0, 1'b0);
      a1 = '0; b1 = '0; c1 = 1'b0;
      a2 = '0; b2 = '0; c2 = 1'b0;
      a3 = '0; b3 = '0; c3 = 1'b0;
      a4 = '0; b4 = '0; c4 = 1'b0;
      #1;
      check("reset_S", 33'(s0), 33'h0);
      check("reset_Cout", 33'(co0), 33'h0);
      #2 rst_n = 1'b1;

      drive0(16'hFFFF, 16'h0000, 1'b1);
      step();
      check("ripple_S", 33'(s0), 33'h0);
      check("ripple_Cout", 33'(co0), 33'h1);

      drive0(16'hD6D8, 16'h1B58, 1'b1);
      step();
      check("dec_S", 33'(s0), 33'hF231);
      check("dec_Cout", 33'(co0), 33'h0);

      drive0(16'd999, 16'd0, 1'b1);
      step();
      check("999_S", 33'(s0), 33'h03E8);
      check("999_Cout", 33'(co0), 33'h0);

      drive0(16'h8000, 16'h8000, 1'b0);
      step();
      check("msb_S", 33'(s0), 33'h0);
      check("msb_Cout", 33'(co0), 33'h1);

      // Reset asserted and released between edges.
      drive0(16'h1234, 16'h1111, 1'b0);
      step();
      check("pre_rst_S", 33'(s0), 33'h2345);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_S", 33'(s0), 33'h0);
      check("async_rst_Cout", 33'(co0), 33'h0);
      step();
      check("hold_rst_S_1", 33'(s0), 33'h0);
      step();
      check("hold_rst_S_2", 33'(s0), 33'h0);
      check("hold_rst_Cout", 33'(co0), 33'h0);
      #2 rst_n = 1'b1;
      #1;
      check("release_no_edge_S", 33'(s0), 33'h0);
      step();
      check("post_rst_S", 33'(s0), 33'h2345);

      // Back-to-back vectors, one per edge.
      drive0(16'h0F0F, 16'h00F1, 1'b0);
      #3 drive0(16'hAAAA, 16'h5555, 1'b0);
      check("between_edges_S", 33'(s0), 33'h2345);
      drive0(16'h0F0F, 16'h00F1, 1'b0);
      step();
      check("b2b_1_S", 33'(s0), 33'h1000);
      drive0(16'hAAAA, 16'h5555, 1'b1);
      step();
      check("b2b_2_S", 33'(s0), 33'h0);
      check("b2b_2_Cout", 33'(co0), 33'h1);
      drive0(16'hFFFF, 16'hFFFF, 1'b1);
      step();
      check("b2b_3_S", 33'(s0), 33'hFFFF);
      check("b2b_3_Cout", 33'(co0), 33'h1);

      for (int n = 0; n < 10000; n++) begin
         a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom_range(0, 1));
         a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom_range(0, 1));
         a2 = $urandom;      b2 = $urandom;      c2 = 1'($urandom_range(0, 1));
         a3 = 8'($urandom);  b3 = 8'($urandom);  c3 = 1'($urandom_range(0, 1));
         a4 = 12'($urandom); b4 = 12'($urandom); c4 = 1'($urandom_range(0, 1));
         // Complementary operands make every group propagate.
         if (n % 4 == 0) begin
            b0 = ~a0; b1 = ~a1; b2 = ~a2; b3 = ~a3; b4 = ~a4;
         end
         e0 = 33'(a0) + 33'(b0) + 33'(c0);
         e1 = 33'(a1) + 33'(b1) + 33'(c1);
         e2 = 33'(a2) + 33'(b2) + 33'(c2);
         e3 = 33'(a3) + 33'(b3) + 33'(c3);
         e4 = 33'(a4) + 33'(b4) + 33'(c4);
         step();
         check("rnd_16_2_4_S",    33'(s0),  33'(e0[15:0]));
         check("rnd_16_2_4_Cout", 33'(co0), 33'(e0[16]));
         check("rnd_16_4_4_S",    33'(s1),  33'(e1[15:0]));
         check("rnd_16_4_4_Cout", 33'(co1), 33'(e1[16]));
         check("rnd_32_2_8_S",    33'(s2),  33'(e2[31:0]));
         check("rnd_32_2_8_Cout", 33'(co2), 33'(e2[32]));
         check("rnd_8_3_4_S",     33'(s3),  33'(e3[7:0]));
         check("rnd_8_3_4_Cout",  33'(co3), 33'(e3[8]));
         check("rnd_12_2_3_S",    33'(s4),  33'(e4[11:0]));
         check("rnd_12_2_3_Cout", 33'(co4), 33'(e4[12]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
